// File: rtl/dark_rr_arbiter.sv
// dark_rr_arbiter: round-robin arbiter and transaction sequencer sharing one
// memory port among NCORES darkmm masters. One core is latched at a time,
// the READY/VALID handshake is run toward memory, and read data is returned
// on a broadcast bus while every other requester is held in halt.
//
// Optional build macro: DARK_ARB_STATS_EN adds the ARB_CNT output carrying a
// saturating 16-bit per-core count of completed turns (timeouts included).
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no owner; pick the next pending core after the RR pointer
// ISSUE  | ARB_VALID high, latched fields held until MEM_READY
// WAIT   | waiting for MEM_VALID; timeout down-counter running
// DONE   | one cycle: owner released from halt, REQ_DATAI valid, pointer moves

module dark_rr_arbiter #(
  parameter int NCORES   = 2,
  parameter int MAX_WAIT = 255
) (
  input  logic                 XCLK,
  input  logic                 XRES,
  input  logic [NCORES*32-1:0] REQ_ADDR,
  input  logic [NCORES*32-1:0] REQ_DATA,
  input  logic [NCORES*4-1:0]  REQ_BE,
  input  logic [NCORES-1:0]    REQ_RD,
  input  logic [NCORES-1:0]    REQ_WR,
  output logic [31:0]          REQ_DATAI,
  output logic [NCORES-1:0]    REQ_HLT,
  output logic [31:0]          ARB_ADDR,
  output logic [31:0]          ARB_DATA,
  output logic [3:0]           ARB_BE,
  output logic                 ARB_RD,
  output logic                 ARB_WR,
  output logic                 ARB_VALID,
  output logic [NCORES-1:0]    ARB_GNT,
  output logic                 ARB_ERR,
`ifdef DARK_ARB_STATS_EN
  output logic [NCORES*16-1:0] ARB_CNT,
`endif
  input  logic                 MEM_READY,
  input  logic                 MEM_VALID,
  input  logic [31:0]          MEM_DATA
);

  localparam int IDXW = (NCORES > 1) ? $clog2(NCORES) : 1;
  // Timer counts down from here; reaching zero without MEM_VALID means the
  // MAX_WAIT-th WAIT cycle has gone by.
  localparam logic [7:0] WAIT_LOAD = 8'(MAX_WAIT - 1);
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [NCORES-1:0] gnt_q, gnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        be_q, be_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [31:0]       datai_q, datai_d;
  logic              err_q, err_d;
  logic [7:0]        wait_q, wait_d;

  logic [NCORES-1:0] pending;
  logic [IDXW-1:0]   pick;

  // Lowest pending index strictly above the pointer wins; if none, wrap and
  // take the lowest pending index at or below it.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NCORES-1:0] pend,
                                              input logic [IDXW-1:0]   ptr);
    logic [IDXW-1:0] res;
    logic            hit;
    res = '0;
    hit = 1'b0;
    for (int j = NCORES - 1; j >= 0; j--) begin
      if (pend[j] && (IDXW'(j) > ptr)) begin
        res = IDXW'(j);
        hit = 1'b1;
      end
    end
    if (!hit) begin
      for (int j = NCORES - 1; j >= 0; j--) begin
        if (pend[j] && (IDXW'(j) <= ptr)) begin
          res = IDXW'(j);
        end
      end
    end
    return res;
  endfunction

  assign pending = REQ_RD | REQ_WR;
  assign pick    = rr_pick(pending, ptr_q);

  // Halt every pending core except the owner during its DONE cycle.
  assign REQ_HLT = pending & ~({NCORES{state_q == ST_DONE}} & gnt_q);

  // Next-state, latch and timer logic for the arbitration sequence.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    datai_d = datai_q;
    err_d   = 1'b0;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (|pending) begin
          idx_d   = pick;
          gnt_d   = NCORES'(1) << pick;
          addr_d  = REQ_ADDR[{pick, 5'd0} +: 32];
          data_d  = REQ_DATA[{pick, 5'd0} +: 32];
          be_d    = REQ_BE[{pick, 2'd0} +: 4];
          rd_d    = REQ_RD[pick];
          wr_d    = REQ_WR[pick];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (MEM_READY) begin
          wait_d  = WAIT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (MEM_VALID) begin
          if (rd_q) begin
            datai_d = MEM_DATA;
          end
          state_d = ST_DONE;
        end else if (wait_q == 8'd0) begin
          datai_d = TIMEOUT_DATA;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      ST_DONE: begin
        ptr_d   = idx_q;
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched-field registers with synchronous reset.
  always_ff @(posedge XCLK) begin
    if (XRES) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDXW'(NCORES - 1);
      idx_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      datai_q <= '0;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      datai_q <= datai_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  assign REQ_DATAI = datai_q;
  assign ARB_ADDR  = addr_q;
  assign ARB_DATA  = data_q;
  assign ARB_BE    = be_q;
  assign ARB_RD    = rd_q;
  assign ARB_WR    = wr_q;
  assign ARB_VALID = (state_q == ST_ISSUE);
  assign ARB_GNT   = gnt_q;
  assign ARB_ERR   = err_q;

`ifdef DARK_ARB_STATS_EN
  logic [15:0] cnt_q [NCORES];
  logic [15:0] cnt_d [NCORES];

  // Count DONE cycles per owner, saturating at all-ones.
  always_comb begin
    for (int j = 0; j < NCORES; j++) begin
      cnt_d[j] = cnt_q[j];
      if ((state_q == ST_DONE) && gnt_q[j] && (cnt_q[j] != 16'hFFFF)) begin
        cnt_d[j] = cnt_q[j] + 16'd1;
      end
    end
  end

  // Turn counters, cleared only by reset.
  always_ff @(posedge XCLK) begin
    if (XRES) begin
      for (int j = 0; j < NCORES; j++) begin
        cnt_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NCORES; j++) begin
        cnt_q[j] <= cnt_d[j];
      end
    end
  end

  for (genvar g = 0; g < NCORES; g++) begin : g_cnt
    assign ARB_CNT[16*g +: 16] = cnt_q[g];
  end
`endif

endmodule
